ifu: RTL and testbench
======================

# ifu

Instruction fetch unit for the single-cycle MIPS core: holds the PC register, reads the instruction ROM, and computes the next PC. It sits directly upstream of the immediate extender and register file, supplying `instr[15:0]` to the extender. It consumes the extender's word-shifted branch offset (`imm_shifted`) to form branch targets. It also keeps a fetch counter for bench and trace use.

## Interface
Parameters:
- `PC_RESET`, 32'h0000_3000: PC value after reset.
- `IM_WORDS`, 1024: instruction ROM depth in words.
- `IM_INIT`, "code.txt": hex image loaded into the ROM at elaboration.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `stall`, in, 1: hold the PC and the counter this cycle.
- `npc_op`, in, 2: next-PC select. 00 = seq, 01 = branch, 10 = jump, 11 = jr.
- `branch_taken`, in, 1: comparator result; meaningful only when `npc_op` = 01.
- `imm_shifted`, in, 32: sign-extended offset shifted left by 2, from the extender.
- `jr_target`, in, 32: GPR[rs] value for jr/jalr.
- `pc`, out, 32: current PC.
- `instr`, out, 32: ROM word at `pc`.
- `pc_plus8`, out, 32: `pc` + 8, the link value for jal/jalr (delay-slot convention).
- `fetch_count`, out, 32: number of PC advances since reset.

## Operation
- ROM index = (`pc` − `PC_RESET`)[log2(IM_WORDS)+1:2]. It wraps modulo `IM_WORDS`, so there is no out-of-range fault.
- The ROM read is combinational: `instr` is valid in the same cycle `pc` changes.
- Next PC, with `seq` = `pc` + 4 in all cases:
  - 00: `seq`.
  - 01: `seq` + `imm_shifted` if `branch_taken`, else `seq`.
  - 10: {`seq`[31:28], `instr`[25:0], 2'b00}.
  - 11: {`jr_target`[31:2], 2'b00}. The low 2 bits are forced to zero; no exception is raised.
- All arithmetic is 32-bit modulo 2^32. Wrap past 32'hFFFF_FFFC to 0 is silent.
- `fetch_count` increments by 1 on every non-stalled edge. It wraps from 32'hFFFF_FFFF to 0.
- Run-state FSM:
  - RESET (`reset_n` low): `pc` is `PC_RESET`, `fetch_count` is 0.
  - RUN: update on each edge where `stall` = 0.
  - HOLD: `stall` = 1. PC and counter are unchanged and `instr` is stable.
  - HOLD returns to RUN on the first edge with `stall` = 0. That edge uses the `npc_op` and inputs present at that edge; nothing is remembered from stalled cycles.

## Timing
- Reset values: `pc` = `PC_RESET`, `fetch_count` = 0, `pc_plus8` = `PC_RESET` + 8, `instr` = ROM[0].
- Asserting `reset_n` low forces these values immediately, without waiting for a clock edge. Deassertion takes effect on the next rising edge.
- Reset mid-operation discards any pending next-PC value.
- Latency:
  - `pc` updates one edge after the select inputs are sampled.
  - `instr`, `pc_plus8` and the index are combinational from `pc`, with 0 extra cycles.
- `stall` combined with any `npc_op`: stall wins and the PC holds.
- `branch_taken` with `npc_op` ≠ 01 is ignored.
- The next-PC path is combinational from `instr`, `imm_shifted`, `jr_target` and `branch_taken` to the PC D-input. No combinational path exists from any input to `pc`.

## Structure
- Shared package `mips_pkg` holds:
  - the `NPC_SEQ`, `NPC_BR`, `NPC_J` and `NPC_JR` 2-bit encodings;
  - the default `PC_RESET`;
  - the `IM_WORDS` default.
- Sub-module `npc` is purely combinational. Inputs: `pc`, `npc_op`, `branch_taken`, `imm_shifted`, `instr_index`, `jr_target`. Outputs: `next_pc` and `pc_plus8`.
- `ifu` owns the PC and counter registers, the ROM, and the stall/reset control.

## Test plan
- Reset and sequential fetch: pulse `reset_n` low mid-cycle, then run 3 edges with `npc_op` = 00.
  - `pc` = 0x3000 immediately on reset, then 0x3004, 0x3008, 0x300C.
  - `fetch_count` = 3.
  - `instr` matches ROM words 0–3.
- Branch: at `pc` = 0x3010 with `npc_op` = 01 and `imm_shifted` = 0xFFFF_FFF0.
  - `branch_taken` = 1: next `pc` = 0x3004.
  - `branch_taken` = 0: next `pc` = 0x3014.
- Jump: `instr` = 0x0800_0C10 at `pc` = 0x3020 with `npc_op` = 10.
  - Next `pc` = 0x0000_3040.
  - `pc_plus8` before the edge = 0x3028.
- jr with misaligned target: `jr_target` = 0x0000_3107, `npc_op` = 11.
  - Next `pc` = 0x0000_3104.
- Stall priority: hold `stall` = 1 for 4 edges with `npc_op` = 10.
  - `pc`, `instr` and `fetch_count` are unchanged.
  - On release, the jump is taken on the first edge.
- Wrap: set `PC_RESET` = 32'hFFFF_FFF8 and run 2 seq edges.
  - `pc` = 0xFFFF_FFFC, then 0x0000_0000.
  - The ROM index wraps modulo `IM_WORDS`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: next-PC select encodings, fetch defaults and
// the built-in instruction image that stands in for the default code file.
package mips_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } run_state_e;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam int          IM_WORDS_DEF = 1024;

  // Word 8 (PC_RESET + 0x20) holds a j to PC_RESET + 0x40; the rest is a
  // deterministic scramble so every fetched word is distinguishable.
  function automatic logic [31:0] im_image(input logic [31:0] idx);
    logic [31:0] w;
    if (idx == 32'd8) begin
      w = 32'h0800_0C10;
    end else begin
      w = ((idx + 32'd1) * 32'h9E37_79B9) ^ {idx[15:0], idx[31:16]};
    end
    return w;
  endfunction

endpackage

// File: rtl/ifu_npc.sv
// Combinational next-PC generator: sequential, branch, jump and register-jump
// targets plus the pc+8 link value.
module npc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic        branch_taken,
  input  logic [31:0] imm_shifted,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus8
);

  logic [31:0] seq;

  assign seq      = pc + 32'd4;
  assign pc_plus8 = pc + 32'd8;

  always_comb begin
    next_pc = seq;
    case (npc_op)
      NPC_BR:  if (branch_taken) next_pc = seq + imm_shifted;
      NPC_J:   next_pc = {seq[31:28], instr_index, 2'b00};
      // Misaligned register targets are silently word-aligned.
      NPC_JR:  next_pc = jr_target & ~32'd3;
      default: next_pc = seq;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, combinational instruction ROM,
// run/hold control and a free-running fetch counter.
module ifu
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int          IM_WORDS = IM_WORDS_DEF,
  parameter string       IM_INIT  = "code.txt"
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        branch_taken,
  input  logic [31:0] imm_shifted,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [31:0] pc_plus8,
  output logic [31:0] fetch_count
);

  localparam int AW        = $clog2(IM_WORDS);
  localparam bit HAS_IMAGE = (IM_INIT != "");

  logic [31:0] pc_p0;
  logic [31:0] count_p0;
  run_state_e  state_p0;
  run_state_e  state_d;
  logic        advance;
  logic [31:0] pc_off;
  logic [AW-1:0] rom_idx;
  logic [31:0] next_pc;

  // Index is relative to the reset PC and wraps with the ROM depth.
  assign pc_off  = pc_p0 - PC_RESET;
  assign rom_idx = AW'(pc_off >> 2);
  assign instr   = HAS_IMAGE ? im_image(32'(rom_idx)) : 32'd0;

  npc u_npc (
    .pc           (pc_p0),
    .npc_op       (npc_op),
    .branch_taken (branch_taken),
    .imm_shifted  (imm_shifted),
    .instr_index  (instr[25:0]),
    .jr_target    (jr_target),
    .next_pc      (next_pc),
    .pc_plus8     (pc_plus8)
  );

  always_comb begin
    state_d = state_p0;
    case (state_p0)
      ST_RUN:  if (stall)  state_d = ST_HOLD;
      ST_HOLD: if (!stall) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  assign advance = (state_d == ST_RUN);

  // p0: architectural fetch state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_p0    <= PC_RESET;
      count_p0 <= 32'd0;
      state_p0 <= ST_RUN;
    end else begin
      state_p0 <= state_d;
      if (advance) begin
        pc_p0    <= next_pc;
        count_p0 <= count_p0 + 32'd1;
      end
    end
  end

  assign pc          = pc_p0;
  assign fetch_count = count_p0;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed fetch/branch/jump/stall/wrap cases
// followed by randomized traffic against a spec-level PC model.
module tb_ifu;
  import mips_pkg::*;

  localparam logic [31:0] BASE   = 32'h0000_3000;
  localparam logic [31:0] W_BASE = 32'hFFFF_FFF8;
  localparam int          WORDS  = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  npc_op = 2'b00;
  logic        branch_taken = 1'b0;
  logic [31:0] imm_shifted = 32'd0;
  logic [31:0] jr_target = 32'd0;
  logic [31:0] pc, instr, pc_plus8, fetch_count;

  logic        w_reset_n = 1'b0;
  logic        w_stall = 1'b0;
  logic [1:0]  w_op = 2'b00;
  logic        w_bt = 1'b0;
  logic [31:0] w_imm = 32'd0;
  logic [31:0] w_jr = 32'd0;
  logic [31:0] w_pc, w_instr, w_pc_plus8, w_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  ifu #(.PC_RESET(BASE), .IM_WORDS(WORDS), .IM_INIT("code.txt")) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .npc_op(npc_op),
    .branch_taken(branch_taken), .imm_shifted(imm_shifted), .jr_target(jr_target),
    .pc(pc), .instr(instr), .pc_plus8(pc_plus8), .fetch_count(fetch_count)
  );

  ifu #(.PC_RESET(W_BASE), .IM_WORDS(WORDS), .IM_INIT("code.txt")) dut_w (
    .clk(clk), .reset_n(w_reset_n), .stall(w_stall), .npc_op(w_op),
    .branch_taken(w_bt), .imm_shifted(w_imm), .jr_target(w_jr),
    .pc(w_pc), .instr(w_instr), .pc_plus8(w_pc_plus8), .fetch_count(w_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Expected ROM word for a PC, given the image contents and the reset base.
  function automatic logic [31:0] rom_at(input logic [31:0] p, input logic [31:0] base);
    return im_image(((p - base) / 4) % WORDS);
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [1:0] op,
                                             input logic bt, input logic [31:0] imm,
                                             input logic [31:0] jr, input logic [31:0] ins);
    logic [31:0] seq;
    seq = p + 32'd4;
    case (op)
      2'b00:   return seq;
      2'b01:   return bt ? seq + imm : seq;
      2'b10:   return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
      default: return jr - (jr % 4);
    endcase
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".instr"}, instr, rom_at(m_pc, BASE));
    chk({tag, ".pc_plus8"}, pc_plus8, m_pc + 32'd8);
    chk({tag, ".count"}, fetch_count, m_cnt);
  endtask

  task automatic step(input string tag, input logic s, input logic [1:0] op, input logic bt,
                      input logic [31:0] imm, input logic [31:0] jr);
    logic [31:0] exp;
    @(negedge clk);
    stall = s; npc_op = op; branch_taken = bt; imm_shifted = imm; jr_target = jr;
    #1;
    exp = model_next(m_pc, op, bt, imm, jr, rom_at(m_pc, BASE));
    @(posedge clk);
    #1;
    if (!s) begin
      m_pc  = exp;
      m_cnt = m_cnt + 32'd1;
    end
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    m_pc = BASE;
    m_cnt = 32'd0;
    check_state(tag);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    m_pc = BASE;
    m_cnt = 32'd0;
    repeat (2) @(posedge clk);
    do_reset("reset");
    chk("reset.instr0", instr, im_image(32'd0));

    for (int i = 0; i < 4; i++) step("seq", 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    chk("seq.pc3010", pc, 32'h0000_3010);

    step("br_taken", 1'b0, 2'b01, 1'b1, 32'hFFFF_FFF0, 32'd0);
    chk("br_taken.target", pc, 32'h0000_3004);
    for (int i = 0; i < 3; i++) step("seq2", 1'b0, 2'b00, 1'b1, 32'hFFFF_FFF0, 32'd0);
    step("br_not", 1'b0, 2'b01, 1'b0, 32'hFFFF_FFF0, 32'd0);
    chk("br_not.target", pc, 32'h0000_3014);
    for (int i = 0; i < 3; i++) step("seq3", 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);

    chk("jump.instr", instr, 32'h0800_0C10);
    chk("jump.link", pc_plus8, 32'h0000_3028);
    step("jump", 1'b0, 2'b10, 1'b1, 32'd0, 32'd0);
    chk("jump.target", pc, 32'h0000_3040);

    step("jr", 1'b0, 2'b11, 1'b0, 32'd0, 32'h0000_3107);
    chk("jr.target", pc, 32'h0000_3104);

    for (int i = 0; i < 4; i++) step("hold", 1'b1, 2'b10, 1'b0, 32'd0, 32'd0);
    chk("hold.pc", pc, 32'h0000_3104);
    step("release", 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);

    for (int i = 0; i < 300; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      step("rand", ($urandom_range(0, 3) == 0), op, 1'($urandom),
           $urandom & 32'hFFFF_FFFC, $urandom);
      if (i == 150) do_reset("midreset");
    end

    // Wrap instance: PC rolls over past the top of the address space.
    @(negedge clk);
    #2 w_reset_n = 1'b0;
    #1;
    chk("wrap.reset_pc", w_pc, W_BASE);
    chk("wrap.reset_instr", w_instr, im_image(32'd0));
    chk("wrap.reset_count", w_count, 32'd0);
    @(posedge clk);
    #1 w_reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("wrap.pc1", w_pc, 32'hFFFF_FFFC);
    chk("wrap.instr1", w_instr, im_image(32'd1));
    chk("wrap.link1", w_pc_plus8, 32'h0000_0004);
    @(posedge clk);
    #1;
    chk("wrap.pc2", w_pc, 32'h0000_0000);
    chk("wrap.instr2", w_instr, im_image(32'd2));
    chk("wrap.count2", w_count, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
